// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl_if
//  Purpose  : Bundles the fetch-stage signals of pc_fetch_ctrl. This covers
//             the PC+4 adder loop, the redirect inputs, the decode stall, the
//             instruction-memory handshake and the status flags.
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if #(
    parameter int N = 32
);
    logic [N-1:0] pc_plus4_i;     // adder result, computed from pc_o
    logic         branch_i;       // redirect request (single-cycle pulse)
    logic [N-1:0] target_i;       // redirect target
    logic         stall_i;        // decode cannot accept an instruction
    logic         imem_ack_i;     // memory returned the word for pc_o
    logic [N-1:0] pc_o;           // current fetch address / adder input
    logic         imem_req_o;     // fetch request
    logic         instr_valid_o;  // returned word is on the correct path
    logic         misaligned_o;   // rejected misaligned redirect target

    // Controller side
    modport master (
        input  pc_plus4_i, branch_i, target_i, stall_i, imem_ack_i,
        output pc_o, imem_req_o, instr_valid_o, misaligned_o
    );

    // Environment side (adder, memory, later stages)
    modport slave (
        output pc_plus4_i, branch_i, target_i, stall_i, imem_ack_i,
        input  pc_o, imem_req_o, instr_valid_o, misaligned_o
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : Program-counter register and instruction-fetch controller. It
//             holds the PC and issues memory requests. It advances the PC by
//             way of the external PC+4 adder and applies branch redirects.
//             A redirect that arrives while a fetch is in flight is deferred
//             until the ack, and the wrong-path word is squashed.
//  Options  : PC_ALIGN_CHECK_EN - when defined, a redirect target that is not
//             word aligned is rejected, and misaligned_o pulses one cycle
//             later. When undefined, the low two target bits are forced to
//             zero and misaligned_o is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  wire logic         clk_i,
    input  wire logic         rst_n_i,
    pc_fetch_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // first cycle after reset
        S_REQ  = 2'd1,   // fetch outstanding or ready to issue
        S_HOLD = 2'd2    // decode stalled
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_target;      // deferred redirect target
    logic         r_pending;     // deferred redirect waiting for the ack
    logic         w_req;
    logic         w_ack;         // ack that is actually honoured
    logic         w_valid;
    logic         w_branch;      // redirect that is accepted
    logic [N-1:0] w_target;      // target as it will be used

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;
    logic w_bad_target;

    assign w_target     = bus.target_i;
    assign w_bad_target = bus.branch_i && (bus.target_i[1:0] != 2'b00);
    // A rejected redirect behaves as if no branch had arrived.
    assign w_branch     = bus.branch_i && !w_bad_target;

    // Report a rejected target one cycle after the branch pulse
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_bad_target;
        end
    end

    assign bus.misaligned_o = r_misaligned;
`else
    logic w_unused_target_lsbs;

    // Word alignment is enforced by dropping the byte-offset bits.
    assign w_target             = {bus.target_i[N-1:2], 2'b00};
    assign w_branch             = bus.branch_i;
    assign w_unused_target_lsbs = ^bus.target_i[1:0];
    assign bus.misaligned_o     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, request and squash decisions
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // A stall drops the request. Any ack in this cycle is
                // therefore not honoured and the word must be re-presented.
                w_req = !bus.stall_i;
                if (bus.stall_i) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.stall_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_ack   = w_req && bus.imem_ack_i;
        // A word fetched before a redirect is on the wrong path.
        w_valid = w_ack && !w_branch && !r_pending;
    end

    // PC register and deferred-redirect bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pc      <= RESET_PC;
            r_target  <= '0;
            r_pending <= 1'b0;
        end else if (w_ack) begin
            r_pending <= 1'b0;
            if (w_branch) begin
                r_pc <= w_target;          // newest redirect wins
            end else if (r_pending) begin
                r_pc <= r_target;
            end else begin
                r_pc <= bus.pc_plus4_i;    // wraps naturally at 2^N
            end
        end else if (w_branch) begin
            if (w_req) begin
                // The request in flight must keep a stable address, so the
                // redirect is deferred until the ack.
                r_target  <= w_target;
                r_pending <= 1'b1;
            end else begin
                // No request is outstanding, so redirect at once. Any older
                // deferred target is superseded.
                r_pc      <= w_target;
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.imem_req_o    = w_req;
    assign bus.instr_valid_o = w_valid;

endmodule
`default_nettype wire
